fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences the instruction ROM: owns the program counter, drives the ROM read address,
//  registers the returned instruction/data pair and issues it to the execute stage over a
//  valid/ready handshake. Handles jumps, halt-opcode detection and restart.
//  Sits between the instruction ROM (combinational lookup) and the CPU execute unit.
// PARAMETERS
//  ADDR_W       8        ROM address / PC width (256 entries)
//  INSTR_W      9        instruction word width
//  DATA_W       16       immediate data word width
//  HALT_OPCODE  9'h100   instruction value that stops fetching (ROM default word)
//  RESET_PC     8'h00    PC value after reset and on start
// PORTS
//  clk         in   1        clock, rising edge
//  rst         in   1        asynchronous, active-high reset
//  start       in   1        pulse: begin or restart fetching at RESET_PC
//  rom_addr    out  ADDR_W   ROM read address (= PC while fetching)
//  rom_instr   in   INSTR_W  ROM instruction for rom_addr, valid same cycle
//  rom_data    in   DATA_W   ROM data word for rom_addr, valid same cycle
//  instr_out   out  INSTR_W  registered instruction to execute stage
//  data_out    out  DATA_W   registered data word to execute stage
//  pc_out      out  ADDR_W   address of the instruction on instr_out
//  instr_valid out  1        instr_out/data_out/pc_out valid
//  exec_ready  in   1        execute stage accepts; transfer when valid & ready
//  jump_en     in   1        load PC from jump_addr (flushes issued instruction)
//  jump_addr   in   ADDR_W   jump target
//  busy        out  1        state is FETCH or ISSUE
//  halted      out  1        state is HALT
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, pc=RESET_PC, rom_addr=RESET_PC, instr_out=0,
//    data_out=0, pc_out=0, instr_valid=0, busy=0, halted=0.
//  - States: IDLE, FETCH, ISSUE, HALT. rom_addr is driven from pc register in all states.
//  - IDLE: start -> FETCH, pc=RESET_PC. Other inputs, incl. jump_en, ignored.
//  - FETCH (1 cycle): if rom_instr==HALT_OPCODE -> HALT, nothing issued, pc unchanged.
//    Else capture rom_instr/rom_data/pc into output regs, instr_valid<=1, pc<=pc+1, -> ISSUE.
//  - ISSUE: outputs held stable while instr_valid & !exec_ready. On valid&ready:
//    instr_valid<=0 -> FETCH. Latency start->first valid = 2 cycles; steady throughput
//    1 instruction / 2 cycles with exec_ready tied high.
//  - jump_en in FETCH or ISSUE: pc<=jump_addr, instr_valid<=0, -> FETCH. Jump wins over a
//    same-cycle handshake (the handshake still counts as accepted) and over halt detection.
//  - PC arithmetic: ADDR_W-bit unsigned, 255+1 wraps to 0 silently; no wrap flag.
//  - HALT: halted=1, instr_valid=0. start -> FETCH with pc=RESET_PC; jump_en ignored.
//  - start while busy: restart, pc=RESET_PC, instr_valid<=0, -> FETCH. start beats jump_en.
//  - exec_ready while instr_valid=0 has no effect.
// STRUCTURE
//  - cpu_pkg: ADDR_W/INSTR_W/DATA_W, HALT_OPCODE, RESET_PC, fetch state encoding
//    (2-bit localparams IDLE=0, FETCH=1, ISSUE=2, HALT=3).
//  - Sub-module prog_counter: ADDR_W register with async reset, load (start/jump) and
//    increment enables, load priority start > jump > increment.
//  - FSM and output registers live in fetch_sequencer; rom_addr is combinational from pc.
// TESTING
//  1 Reset mid-ISSUE with instr_valid=1 -> same cycle: instr_valid=0, rom_addr=0, state IDLE.
//  2 ROM[0..2]={9'h001/16'h0A, 9'h002/16'h0B, 9'h100}, ready=1, start -> valid at +2 cycles
//    with instr 9'h001/pc 0, then 9'h002/pc 1 two cycles later, then halted=1, no 3rd valid.
//  3 exec_ready=0 for 5 cycles after first valid -> instr_out/data_out/pc_out stable, pc=1.
//  4 jump_en=1, jump_addr=8'h40 in same cycle as valid&ready -> next issued pc_out=8'h40.
//  5 jump_addr=8'hFF, ROM[FF]=9'h003, ROM[0]=9'h004 -> issues pc FF then pc 00 (wrap).
//  6 In HALT pulse start -> halted=0, first instruction re-issued from pc 0 after 2 cycles.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared widths, constants and state encoding for the instruction fetch sequencer.
package fetch_sequencer_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 9;
  localparam int DATA_W  = 16;

  localparam logic [INSTR_W-1:0] HALT_OPCODE = 9'h100;
  localparam logic [ADDR_W-1:0]  RESET_PC    = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// ROM lookup, execute-stage handshake and control signals of the fetch sequencer.
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
();

  logic               start;
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_instr;
  logic [DATA_W-1:0]  rom_data;
  logic [INSTR_W-1:0] instr_out;
  logic [DATA_W-1:0]  data_out;
  logic [ADDR_W-1:0]  pc_out;
  logic               instr_valid;
  logic               exec_ready;
  logic               jump_en;
  logic [ADDR_W-1:0]  jump_addr;
  logic               busy;
  logic               halted;

  modport master (
    input  start, rom_instr, rom_data, exec_ready, jump_en, jump_addr,
    output rom_addr, instr_out, data_out, pc_out, instr_valid, busy, halted
  );

  modport slave (
    output start, rom_instr, rom_data, exec_ready, jump_en, jump_addr,
    input  rom_addr, instr_out, data_out, pc_out, instr_valid, busy, halted
  );

endinterface

// File: rtl/fetch_sequencer_prog_counter.sv
// Program counter register: load priority start > jump > increment, wraps silently.
module fetch_sequencer_prog_counter
  import fetch_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (start_i) begin
      pc_d = RESET_PC;
    end else if (jump_i) begin
      pc_d = jump_addr_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: walks the instruction ROM and hands each word to the execute stage.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master bus_io
);

  fetch_state_e       state_q;
  logic [INSTR_W-1:0] instr_q;
  logic [DATA_W-1:0]  data_q;
  logic [ADDR_W-1:0]  pc_out_q;
  logic               valid_q;

  logic [ADDR_W-1:0]  pc;
  logic               is_halt_op;
  logic               jump_take;
  logic               pc_inc;

  assign is_halt_op = (bus_io.rom_instr == HALT_OPCODE);
  assign jump_take  = bus_io.jump_en && ((state_q == FETCH) || (state_q == ISSUE));
  assign pc_inc     = (state_q == FETCH) && !bus_io.start && !bus_io.jump_en && !is_halt_op;

  fetch_sequencer_prog_counter u_pc (
    .clk         (clk),
    .rst         (rst),
    .start_i     (bus_io.start),
    .jump_i      (jump_take),
    .jump_addr_i (bus_io.jump_addr),
    .inc_i       (pc_inc),
    .pc_o        (pc)
  );

  // start restarts from any state; a jump flushes whatever is being issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      data_q   <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
    end else if (bus_io.start) begin
      state_q <= FETCH;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        FETCH: begin
          if (bus_io.jump_en) begin
            state_q <= FETCH;
            valid_q <= 1'b0;
          end else if (is_halt_op) begin
            state_q <= HALT;
            valid_q <= 1'b0;
          end else begin
            instr_q  <= bus_io.rom_instr;
            data_q   <= bus_io.rom_data;
            pc_out_q <= pc;
            valid_q  <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus_io.jump_en || (valid_q && bus_io.exec_ready)) begin
            valid_q <= 1'b0;
            state_q <= FETCH;
          end
        end
        HALT: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_io.rom_addr    = pc;
  assign bus_io.instr_out   = instr_q;
  assign bus_io.data_out    = data_q;
  assign bus_io.pc_out      = pc_out_q;
  assign bus_io.instr_valid = valid_q;
  assign bus_io.busy        = (state_q == FETCH) || (state_q == ISSUE);
  assign bus_io.halted      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a ROM model feeds the DUT, expected issues are queued.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  data;
    logic [ADDR_W-1:0]  pc;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [INSTR_W-1:0] romInstr [256];
  logic [DATA_W-1:0]  romData  [256];
  txn_t               expQ [$];
  txn_t               monExp;
  txn_t               monGot;

  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.rom_instr = romInstr[bus.rom_addr];
  assign bus.rom_data  = romData[bus.rom_addr];

  // Every accepted transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.instr_valid && bus.exec_ready) begin
      checks++;
      monGot = '{instr: bus.instr_out, data: bus.data_out, pc: bus.pc_out};
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL issue_unexpected: got instr=%h data=%h pc=%h, required no issue",
                 monGot.instr, monGot.data, monGot.pc);
      end else begin
        monExp = expQ.pop_front();
        if (monGot !== monExp) begin
          errors++;
          $display("[TB] FAIL issue_content: got instr=%h data=%h pc=%h, required instr=%h data=%h pc=%h",
                   monGot.instr, monGot.data, monGot.pc, monExp.instr, monExp.data, monExp.pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearRom();
    for (int i = 0; i < 256; i++) begin
      romInstr[i] = HALT_OPCODE;
      romData[i]  = '0;
    end
  endtask

  task automatic applyStimulus(input logic [INSTR_W-1:0] instr, input logic [DATA_W-1:0] data,
                               input logic [ADDR_W-1:0] addr);
    romInstr[addr] = instr;
    romData[addr]  = data;
  endtask

  task automatic pulseStart();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic waitHalted(input string name);
    int n = 0;
    while (!bus.halted && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (bus.halted !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_halt_timeout: got halted=%b, required 1 within 40 cycles", name, bus.halted);
    end
  endtask

  task automatic checkDrained(input string name);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drained: got %0d pending issues, required 0", name, expQ.size());
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({bus.instr_valid, bus.busy, bus.halted} !== 3'b000 || bus.rom_addr !== 8'h00 ||
        bus.instr_out !== 9'h000 || bus.data_out !== 16'h0000 || bus.pc_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_state: got valid=%b busy=%b halted=%b addr=%h instr=%h data=%h pc=%h, required all zero",
               bus.instr_valid, bus.busy, bus.halted, bus.rom_addr, bus.instr_out, bus.data_out, bus.pc_out);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_issue();
    clearRom();
    applyStimulus(9'h001, 16'h000A, 8'h00);
    bus.exec_ready = 1'b0;
    pulseStart();
    step();
    checks++;
    if (bus.instr_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_issue_valid: got valid=%b, required 1", bus.instr_valid);
    end
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.rom_addr !== 8'h00 || bus.busy !== 1'b0 ||
        bus.halted !== 1'b0 || bus.instr_out !== 9'h000 || bus.pc_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL async_reset: got valid=%b addr=%h busy=%b halted=%b instr=%h pc=%h, required 0/00/0/0/000/00",
               bus.instr_valid, bus.rom_addr, bus.busy, bus.halted, bus.instr_out, bus.pc_out);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_program();
    clearRom();
    applyStimulus(9'h001, 16'h000A, 8'h00);
    applyStimulus(9'h002, 16'h000B, 8'h01);
    bus.exec_ready = 1'b1;
    expQ.push_back('{instr: 9'h001, data: 16'h000A, pc: 8'h00});
    expQ.push_back('{instr: 9'h002, data: 16'h000B, pc: 8'h01});
    pulseStart();
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL program_fetch_state: got valid=%b busy=%b, required 0/1", bus.instr_valid, bus.busy);
    end
    step();
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.pc_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL program_latency: got valid=%b pc=%h two cycles after start, required 1/00",
               bus.instr_valid, bus.pc_out);
    end
    waitHalted("program");
    repeat (3) step();
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.halted !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL program_halt_quiet: got valid=%b halted=%b busy=%b, required 0/1/0",
               bus.instr_valid, bus.halted, bus.busy);
    end
    checkDrained("program");
  endtask

  task automatic test_stall();
    bus.exec_ready = 1'b0;
    expQ.push_back('{instr: 9'h001, data: 16'h000A, pc: 8'h00});
    expQ.push_back('{instr: 9'h002, data: 16'h000B, pc: 8'h01});
    pulseStart();
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_out !== 9'h001 || bus.data_out !== 16'h000A ||
          bus.pc_out !== 8'h00 || bus.rom_addr !== 8'h01) begin
        errors++;
        $display("[TB] FAIL stall_hold: cycle %0d got valid=%b instr=%h data=%h pc=%h addr=%h, required 1/001/000a/00/01",
                 i, bus.instr_valid, bus.instr_out, bus.data_out, bus.pc_out, bus.rom_addr);
      end
    end
    bus.exec_ready = 1'b1;
    waitHalted("stall");
    checkDrained("stall");
  endtask

  task automatic test_jump();
    applyStimulus(9'h005, 16'h0055, 8'h40);
    bus.exec_ready = 1'b1;
    expQ.push_back('{instr: 9'h001, data: 16'h000A, pc: 8'h00});
    expQ.push_back('{instr: 9'h005, data: 16'h0055, pc: 8'h40});
    pulseStart();
    step();
    bus.jump_en   = 1'b1;
    bus.jump_addr = 8'h40;
    step();
    bus.jump_en = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.rom_addr !== 8'h40) begin
      errors++;
      $display("[TB] FAIL jump_target: got valid=%b addr=%h, required 0/40", bus.instr_valid, bus.rom_addr);
    end
    waitHalted("jump");
    checkDrained("jump");
  endtask

  task automatic test_back_to_back_wrap();
    clearRom();
    applyStimulus(9'h003, 16'h00F0, 8'hFF);
    applyStimulus(9'h004, 16'h0044, 8'h00);
    bus.exec_ready = 1'b1;
    expQ.push_back('{instr: 9'h003, data: 16'h00F0, pc: 8'hFF});
    expQ.push_back('{instr: 9'h004, data: 16'h0044, pc: 8'h00});
    pulseStart();
    bus.jump_en   = 1'b1;
    bus.jump_addr = 8'hFF;
    step();
    bus.jump_en = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.rom_addr !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL wrap_jump: got valid=%b addr=%h, required 0/ff", bus.instr_valid, bus.rom_addr);
    end
    waitHalted("wrap");
    checkDrained("wrap");
  endtask

  task automatic test_restart();
    bus.exec_ready = 1'b1;
    expQ.push_back('{instr: 9'h004, data: 16'h0044, pc: 8'h00});
    pulseStart();
    checks++;
    if (bus.halted !== 1'b0 || bus.busy !== 1'b1 || bus.rom_addr !== 8'h00) begin
      errors++;
      $display("[TB] FAIL restart_state: got halted=%b busy=%b addr=%h, required 0/1/00",
               bus.halted, bus.busy, bus.rom_addr);
    end
    step();
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.pc_out !== 8'h00 || bus.instr_out !== 9'h004) begin
      errors++;
      $display("[TB] FAIL restart_first_issue: got valid=%b pc=%h instr=%h, required 1/00/004",
               bus.instr_valid, bus.pc_out, bus.instr_out);
    end
    waitHalted("restart");
    checkDrained("restart");
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.exec_ready = 1'b0;
    bus.jump_en    = 1'b0;
    bus.jump_addr  = '0;
    clearRom();
    test_reset();
    test_reset_mid_issue();
    test_program();
    test_stall();
    test_jump();
    test_back_to_back_wrap();
    test_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
